// File: rtl/instr_encoder.sv
// Shared order codes (same numbering the decode stage produces) and the
// pipelined MIPS instruction encoder.
// Latency 1 cycle accept->out_valid; one-entry output register, full valid/ready.

package instr_encoder_pkg;
   localparam logic [6:0] ORD_NONE  = 7'd0;
   localparam logic [6:0] ORD_SLL   = 7'd1;
   localparam logic [6:0] ORD_SRL   = 7'd2;
   localparam logic [6:0] ORD_SRA   = 7'd3;
   localparam logic [6:0] ORD_SLLV  = 7'd4;
   localparam logic [6:0] ORD_SRLV  = 7'd5;
   localparam logic [6:0] ORD_SRAV  = 7'd6;
   localparam logic [6:0] ORD_JR    = 7'd7;
   localparam logic [6:0] ORD_JALR  = 7'd8;
   localparam logic [6:0] ORD_MFHI  = 7'd9;
   localparam logic [6:0] ORD_MFLO  = 7'd10;
   localparam logic [6:0] ORD_MTHI  = 7'd11;
   localparam logic [6:0] ORD_MTLO  = 7'd12;
   localparam logic [6:0] ORD_MULT  = 7'd13;
   localparam logic [6:0] ORD_MULTU = 7'd14;
   localparam logic [6:0] ORD_DIV   = 7'd15;
   localparam logic [6:0] ORD_DIVU  = 7'd16;
   localparam logic [6:0] ORD_ADD   = 7'd17;
   localparam logic [6:0] ORD_ADDU  = 7'd18;
   localparam logic [6:0] ORD_SUB   = 7'd19;
   localparam logic [6:0] ORD_SUBU  = 7'd20;
   localparam logic [6:0] ORD_AND   = 7'd21;
   localparam logic [6:0] ORD_OR    = 7'd22;
   localparam logic [6:0] ORD_XOR   = 7'd23;
   localparam logic [6:0] ORD_NOR   = 7'd24;
   localparam logic [6:0] ORD_SLT   = 7'd25;
   localparam logic [6:0] ORD_SLTU  = 7'd26;
   localparam logic [6:0] ORD_BLTZ  = 7'd27;
   localparam logic [6:0] ORD_BGEZ  = 7'd28;
   localparam logic [6:0] ORD_J     = 7'd29;
   localparam logic [6:0] ORD_JAL   = 7'd30;
   localparam logic [6:0] ORD_BEQ   = 7'd31;
   localparam logic [6:0] ORD_BNE   = 7'd32;
   localparam logic [6:0] ORD_BLEZ  = 7'd33;
   localparam logic [6:0] ORD_BGTZ  = 7'd34;
   localparam logic [6:0] ORD_ADDI  = 7'd35;
   localparam logic [6:0] ORD_ADDIU = 7'd36;
   localparam logic [6:0] ORD_SLTI  = 7'd37;
   localparam logic [6:0] ORD_SLTIU = 7'd38;
   localparam logic [6:0] ORD_ANDI  = 7'd39;
   localparam logic [6:0] ORD_ORI   = 7'd40;
   localparam logic [6:0] ORD_XORI  = 7'd41;
   localparam logic [6:0] ORD_LUI   = 7'd42;
   localparam logic [6:0] ORD_MFC0  = 7'd43;
   localparam logic [6:0] ORD_MTC0  = 7'd44;
   localparam logic [6:0] ORD_ERET  = 7'd45;
   localparam logic [6:0] ORD_LB    = 7'd46;
   localparam logic [6:0] ORD_LH    = 7'd47;
   localparam logic [6:0] ORD_LW    = 7'd48;
   localparam logic [6:0] ORD_LBU   = 7'd49;
   localparam logic [6:0] ORD_LHU   = 7'd50;
   localparam logic [6:0] ORD_SB    = 7'd51;
   localparam logic [6:0] ORD_SH    = 7'd52;
   localparam logic [6:0] ORD_SW    = 7'd53;
endpackage

// Encodes one decoded operation per handshake into a 32-bit MIPS word tagged with its address.
// Latency: one cycle from accept to out_valid; one word per cycle with out_ready high.
// Backpressure: in_ready = !out_valid || out_ready; a stalled word holds until taken.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [6:0]  in_order,
   input  logic [4:0]  in_rs,
   input  logic [4:0]  in_rt,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_shamt,
   input  logic [15:0] in_imm,
   input  logic [25:0] in_target,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_addr,
   output logic        err,
   output logic [15:0] count
);

   logic [31:0] next_addr;
   logic [31:0] enc_word;
   logic        enc_legal;
   logic        accept;
   logic        deliver;

   function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
      return {6'd0, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   // The slot frees up when empty or when its word leaves this cycle; in_valid never feeds back.
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign deliver  = out_valid && out_ready;

   // Encode the offered operation; fields an order does not use are forced to zero.
   always_comb begin
      enc_word  = 32'd0;
      enc_legal = 1'b1;
      case (in_order)
         ORD_SLL:   enc_word = r_word(5'd0, in_rt, in_rd, in_shamt, 6'd0);
         ORD_SRL:   enc_word = r_word(5'd0, in_rt, in_rd, in_shamt, 6'd2);
         ORD_SRA:   enc_word = r_word(5'd0, in_rt, in_rd, in_shamt, 6'd3);
         ORD_SLLV:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'd4);
         ORD_SRLV:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'd6);
         ORD_SRAV:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'd7);
         ORD_JR:    enc_word = r_word(in_rs, 5'd0, 5'd0, 5'd0, 6'd8);
         ORD_JALR:  enc_word = r_word(in_rs, 5'd0, in_rd, 5'd0, 6'd9);
         ORD_MFHI:  enc_word = r_word(5'd0, 5'd0, in_rd, 5'd0, 6'd16);
         ORD_MTHI:  enc_word = r_word(in_rs, 5'd0, 5'd0, 5'd0, 6'd17);
         ORD_MFLO:  enc_word = r_word(5'd0, 5'd0, in_rd, 5'd0, 6'd18);
         ORD_MTLO:  enc_word = r_word(in_rs, 5'd0, 5'd0, 5'd0, 6'd19);
         ORD_MULT:  enc_word = r_word(in_rs, in_rt, 5'd0, 5'd0, 6'd24);
         ORD_MULTU: enc_word = r_word(in_rs, in_rt, 5'd0, 5'd0, 6'd25);
         ORD_DIV:   enc_word = r_word(in_rs, in_rt, 5'd0, 5'd0, 6'd26);
         ORD_DIVU:  enc_word = r_word(in_rs, in_rt, 5'd0, 5'd0, 6'd27);
         ORD_ADD:   enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'd32);
         ORD_ADDU:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'd33);
         ORD_SUB:   enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'd34);
         ORD_SUBU:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'd35);
         ORD_AND:   enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'd36);
         ORD_OR:    enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'd37);
         ORD_XOR:   enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'd38);
         ORD_NOR:   enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'd39);
         ORD_SLT:   enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'd42);
         ORD_SLTU:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, 6'd43);
         // REGIMM: the rt slot selects the branch condition
         ORD_BLTZ:  enc_word = i_word(6'd1, in_rs, 5'd0, in_imm);
         ORD_BGEZ:  enc_word = i_word(6'd1, in_rs, 5'd1, in_imm);
         ORD_J:     enc_word = {6'd2, in_target};
         ORD_JAL:   enc_word = {6'd3, in_target};
         ORD_BEQ:   enc_word = i_word(6'd4, in_rs, in_rt, in_imm);
         ORD_BNE:   enc_word = i_word(6'd5, in_rs, in_rt, in_imm);
         ORD_BLEZ:  enc_word = i_word(6'd6, in_rs, 5'd0, in_imm);
         ORD_BGTZ:  enc_word = i_word(6'd7, in_rs, 5'd0, in_imm);
         ORD_ADDI:  enc_word = i_word(6'd8, in_rs, in_rt, in_imm);
         ORD_ADDIU: enc_word = i_word(6'd9, in_rs, in_rt, in_imm);
         ORD_SLTI:  enc_word = i_word(6'd10, in_rs, in_rt, in_imm);
         ORD_SLTIU: enc_word = i_word(6'd11, in_rs, in_rt, in_imm);
         ORD_ANDI:  enc_word = i_word(6'd12, in_rs, in_rt, in_imm);
         ORD_ORI:   enc_word = i_word(6'd13, in_rs, in_rt, in_imm);
         ORD_XORI:  enc_word = i_word(6'd14, in_rs, in_rt, in_imm);
         ORD_LUI:   enc_word = i_word(6'd15, 5'd0, in_rt, in_imm);
         // COP0 moves: rs slot is the MF/MT selector, low 11 bits stay zero
         ORD_MFC0:  enc_word = {6'd16, 5'd0, in_rt, in_rd, 11'd0};
         ORD_MTC0:  enc_word = {6'd16, 5'd4, in_rt, in_rd, 11'd0};
         ORD_ERET:  enc_word = 32'h4200_0018;
         ORD_LB:    enc_word = i_word(6'd32, in_rs, in_rt, in_imm);
         ORD_LH:    enc_word = i_word(6'd33, in_rs, in_rt, in_imm);
         ORD_LW:    enc_word = i_word(6'd35, in_rs, in_rt, in_imm);
         ORD_LBU:   enc_word = i_word(6'd36, in_rs, in_rt, in_imm);
         ORD_LHU:   enc_word = i_word(6'd37, in_rs, in_rt, in_imm);
         ORD_SB:    enc_word = i_word(6'd40, in_rs, in_rt, in_imm);
         ORD_SH:    enc_word = i_word(6'd41, in_rs, in_rt, in_imm);
         ORD_SW:    enc_word = i_word(6'd43, in_rs, in_rt, in_imm);
         default:   enc_legal = 1'b0;
      endcase
   end

   // Output register, address counter, sticky error and delivery count; reset wins over everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_instr <= 32'd0;
         out_addr  <= BASE_ADDR;
         next_addr <= BASE_ADDR;
         err       <= 1'b0;
         count     <= 16'd0;
      end else begin
         if (deliver) begin
            count <= count + 16'd1;
         end
         if (accept && enc_legal) begin
            out_instr <= enc_word;
            out_addr  <= next_addr;
            next_addr <= next_addr + 32'd4;
            out_valid <= 1'b1;
         end else begin
            // An illegal op is swallowed without consuming an address
            if (accept) begin
               err <= 1'b1;
            end
            if (deliver) begin
               out_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: table-driven reference encoder plus a one-slot transaction
// model compared every cycle, directed literal checks, then randomized traffic.
module tb_instr_encoder;
   import instr_encoder_pkg::*;

   localparam logic [31:0] BASE = 32'h0000_3000;
   localparam int M_RS = 1, M_RT = 2, M_RD = 4, M_SH = 8, M_IM = 16, M_TG = 32;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [6:0]  in_order = '0;
   logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
   logic [15:0] in_imm = '0;
   logic [25:0] in_target = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr, out_addr;
   logic        err;
   logic [15:0] count;

   instr_encoder #(.BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_order(in_order),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
      .in_imm(in_imm), .in_target(in_target),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_addr(out_addr), .err(err), .count(count)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---- reference encoding table, indexed by order code ----
   bit       t_legal [128];
   int       t_op    [128];
   int       t_fn    [128];
   int       t_mask  [128];
   int       t_frs   [128];
   int       t_frt   [128];

   function automatic void ent(input logic [6:0] c, input int op, input int fn,
                               input int mask, input int frs, input int frt);
      t_legal[c] = 1'b1; t_op[c] = op; t_fn[c] = fn;
      t_mask[c] = mask; t_frs[c] = frs; t_frt[c] = frt;
   endfunction

   initial begin
      for (int i = 0; i < 128; i++) begin
         t_legal[i] = 1'b0; t_op[i] = 0; t_fn[i] = 0; t_mask[i] = 0; t_frs[i] = 0; t_frt[i] = 0;
      end
      ent(ORD_SLL, 0, 0, M_RT|M_RD|M_SH, 0, 0);  ent(ORD_SRL, 0, 2, M_RT|M_RD|M_SH, 0, 0);
      ent(ORD_SRA, 0, 3, M_RT|M_RD|M_SH, 0, 0);
      ent(ORD_SLLV, 0, 4, M_RS|M_RT|M_RD, 0, 0); ent(ORD_SRLV, 0, 6, M_RS|M_RT|M_RD, 0, 0);
      ent(ORD_SRAV, 0, 7, M_RS|M_RT|M_RD, 0, 0);
      ent(ORD_JR, 0, 8, M_RS, 0, 0);             ent(ORD_JALR, 0, 9, M_RS|M_RD, 0, 0);
      ent(ORD_MFHI, 0, 16, M_RD, 0, 0);          ent(ORD_MFLO, 0, 18, M_RD, 0, 0);
      ent(ORD_MTHI, 0, 17, M_RS, 0, 0);          ent(ORD_MTLO, 0, 19, M_RS, 0, 0);
      ent(ORD_MULT, 0, 24, M_RS|M_RT, 0, 0);     ent(ORD_MULTU, 0, 25, M_RS|M_RT, 0, 0);
      ent(ORD_DIV, 0, 26, M_RS|M_RT, 0, 0);      ent(ORD_DIVU, 0, 27, M_RS|M_RT, 0, 0);
      ent(ORD_ADD, 0, 32, M_RS|M_RT|M_RD, 0, 0); ent(ORD_ADDU, 0, 33, M_RS|M_RT|M_RD, 0, 0);
      ent(ORD_SUB, 0, 34, M_RS|M_RT|M_RD, 0, 0); ent(ORD_SUBU, 0, 35, M_RS|M_RT|M_RD, 0, 0);
      ent(ORD_AND, 0, 36, M_RS|M_RT|M_RD, 0, 0); ent(ORD_OR, 0, 37, M_RS|M_RT|M_RD, 0, 0);
      ent(ORD_XOR, 0, 38, M_RS|M_RT|M_RD, 0, 0); ent(ORD_NOR, 0, 39, M_RS|M_RT|M_RD, 0, 0);
      ent(ORD_SLT, 0, 42, M_RS|M_RT|M_RD, 0, 0); ent(ORD_SLTU, 0, 43, M_RS|M_RT|M_RD, 0, 0);
      ent(ORD_BLTZ, 1, 0, M_RS|M_IM, 0, 0);      ent(ORD_BGEZ, 1, 0, M_RS|M_IM, 0, 1);
      ent(ORD_J, 2, 0, M_TG, 0, 0);              ent(ORD_JAL, 3, 0, M_TG, 0, 0);
      ent(ORD_BEQ, 4, 0, M_RS|M_RT|M_IM, 0, 0);  ent(ORD_BNE, 5, 0, M_RS|M_RT|M_IM, 0, 0);
      ent(ORD_BLEZ, 6, 0, M_RS|M_IM, 0, 0);      ent(ORD_BGTZ, 7, 0, M_RS|M_IM, 0, 0);
      ent(ORD_ADDI, 8, 0, M_RS|M_RT|M_IM, 0, 0); ent(ORD_ADDIU, 9, 0, M_RS|M_RT|M_IM, 0, 0);
      ent(ORD_SLTI, 10, 0, M_RS|M_RT|M_IM, 0, 0); ent(ORD_SLTIU, 11, 0, M_RS|M_RT|M_IM, 0, 0);
      ent(ORD_ANDI, 12, 0, M_RS|M_RT|M_IM, 0, 0); ent(ORD_ORI, 13, 0, M_RS|M_RT|M_IM, 0, 0);
      ent(ORD_XORI, 14, 0, M_RS|M_RT|M_IM, 0, 0); ent(ORD_LUI, 15, 0, M_RT|M_IM, 0, 0);
      ent(ORD_MFC0, 16, 0, M_RT|M_RD, 0, 0);     ent(ORD_MTC0, 16, 0, M_RT|M_RD, 4, 0);
      ent(ORD_ERET, 16, 24, 0, 16, 0);
      ent(ORD_LB, 32, 0, M_RS|M_RT|M_IM, 0, 0);  ent(ORD_LH, 33, 0, M_RS|M_RT|M_IM, 0, 0);
      ent(ORD_LW, 35, 0, M_RS|M_RT|M_IM, 0, 0);  ent(ORD_LBU, 36, 0, M_RS|M_RT|M_IM, 0, 0);
      ent(ORD_LHU, 37, 0, M_RS|M_RT|M_IM, 0, 0); ent(ORD_SB, 40, 0, M_RS|M_RT|M_IM, 0, 0);
      ent(ORD_SH, 41, 0, M_RS|M_RT|M_IM, 0, 0);  ent(ORD_SW, 43, 0, M_RS|M_RT|M_IM, 0, 0);
   end

   function automatic logic [31:0] ref_enc(input logic [6:0] c);
      int m, rs, rt, rd, sh, im, tg;
      m  = t_mask[c];
      rs = ((m & M_RS) != 0) ? int'(in_rs) : t_frs[c];
      rt = ((m & M_RT) != 0) ? int'(in_rt) : t_frt[c];
      rd = ((m & M_RD) != 0) ? int'(in_rd) : 0;
      sh = ((m & M_SH) != 0) ? int'(in_shamt) : 0;
      im = ((m & M_IM) != 0) ? int'(in_imm) : 0;
      tg = ((m & M_TG) != 0) ? int'(in_target) : 0;
      return 32'(t_op[c] * 67108864 + rs * 2097152 + rt * 65536 + rd * 2048
                 + sh * 64 + t_fn[c] + im + tg);
   endfunction

   // ---- transaction model: the single held word plus bookkeeping ----
   bit          armed = 1'b0;
   bit          mv;
   logic [31:0] mi, ma, na;
   bit          merr;
   int          mcnt;
   logic [63:0] dq[$];   // words actually delivered by the DUT: {instr, addr}

   // Compare every cycle at negedge, then advance the model to the next rising edge.
   always @(negedge clk) begin
      bit acc, del;
      if (armed) begin
         chk("out_valid", 32'(out_valid), 32'(mv));
         chk("out_instr", out_instr, mi);
         chk("out_addr", out_addr, ma);
         chk("in_ready", 32'(in_ready), 32'(!mv || out_ready));
         chk("err", 32'(err), 32'(merr));
         chk("count", 32'(count), 32'(mcnt & 16'hFFFF));
      end
      if (!reset && out_valid === 1'b1 && out_ready) dq.push_back({out_instr, out_addr});
      if (reset) begin
         armed = 1'b1; mv = 1'b0; mi = 32'd0; ma = BASE; na = BASE; merr = 1'b0; mcnt = 0;
      end else if (armed) begin
         del = mv && out_ready;
         acc = in_valid && (!mv || out_ready);
         if (del) mcnt = mcnt + 1;
         if (acc && t_legal[in_order]) begin
            mi = ref_enc(in_order); ma = na; na = na + 32'd4; mv = 1'b1;
         end else begin
            if (acc) merr = 1'b1;
            if (del) mv = 1'b0;
         end
      end
   end

   // ---- driver helpers (called at posedge+1) ----
   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic send(input logic [6:0] o, input int rs, input int rt, input int rd,
                       input int sh, input int imm, input int tg);
      bit ok;
      int n;
      in_valid = 1'b1; in_order = o;
      in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd); in_shamt = 5'(sh);
      in_imm = 16'(imm); in_target = 26'(tg);
      ok = 1'b0; n = 0;
      while (!ok && n < 50) begin
         @(negedge clk); ok = in_ready;
         @(posedge clk); #1;
         n++;
      end
      if (!ok) chk("send_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      idle(2);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_addr", out_addr, BASE);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      // basic stream
      out_ready = 1'b1;
      send(ORD_ADDU, 1, 2, 3, 0, 0, 0);
      send(ORD_ORI, 0, 1, 0, 0, 16'h1234, 0);
      idle(2);
      chk("basic_n", 32'(dq.size()), 32'd2);
      if (dq.size() >= 2) begin
         chk("addu_instr", dq[0][63:32], 32'h0022_1821); chk("addu_addr", dq[0][31:0], 32'h3000);
         chk("ori_instr", dq[1][63:32], 32'h3401_1234);  chk("ori_addr", dq[1][31:0], 32'h3004);
      end
      chk("basic_count", 32'(count), 32'd2);

      // field masking and special encodings
      send(ORD_SLL, 31, 1, 2, 4, 16'hFFFF, 0);
      send(ORD_ERET, 7, 7, 7, 7, 16'hFFFF, 26'h3FFFFFF);
      send(ORD_JAL, 0, 0, 0, 0, 0, 26'h0000C03);
      send(ORD_BGEZ, 5, 9, 0, 0, 16'hFFFE, 0);
      send(ORD_MTC0, 3, 2, 12, 5, 16'hFFFF, 0);
      idle(2);
      chk("special_n", 32'(dq.size()), 32'd7);
      if (dq.size() >= 7) begin
         chk("sll_mask", dq[2][63:32], 32'h0001_1100);
         chk("eret", dq[3][63:32], 32'h4200_0018);
         chk("jal", dq[4][63:32], 32'h0C00_0C03);
         chk("bgez", dq[5][63:32], 32'h04A1_FFFE);
         chk("mtc0", dq[6][63:32], 32'h4082_6000);
         chk("mtc0_addr", dq[6][31:0], 32'h3018);
      end

      // backpressure
      do_reset(); dq.delete();
      out_ready = 1'b0;
      fork
         begin
            send(ORD_ADD, 1, 2, 3, 0, 0, 0);
            send(ORD_SUB, 4, 5, 6, 0, 0, 0);
            send(ORD_OR, 7, 8, 9, 0, 0, 0);
            send(ORD_XOR, 10, 11, 12, 0, 0, 0);
         end
         begin
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_addr", out_addr, 32'h3000);
            chk("stall_instr", out_instr, 32'h0022_1820);
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      idle(2);
      chk("bp_n", 32'(dq.size()), 32'd4);
      for (int i = 0; i < 4 && i < dq.size(); i++)
         chk("bp_addr", dq[i][31:0], 32'h3000 + 32'(4 * i));
      if (dq.size() >= 2) chk("bp_sub", dq[1][63:32], 32'h0085_3022);
      chk("bp_count", 32'(count), 32'd4);

      // illegal order
      do_reset(); dq.delete();
      send(ORD_NONE, 1, 2, 3, 4, 5, 6);
      send(ORD_LW, 29, 8, 0, 0, 4, 0);
      idle(2);
      @(negedge clk);
      chk("ill_err", 32'(err), 32'd1);
      chk("ill_n", 32'(dq.size()), 32'd1);
      if (dq.size() >= 1) begin
         chk("lw_instr", dq[0][63:32], 32'h8FA8_0004);
         chk("lw_addr", dq[0][31:0], 32'h3000);
      end
      @(posedge clk); #1;

      // reset mid-stream with a word pending
      out_ready = 1'b0;
      send(ORD_ADDU, 1, 1, 1, 0, 0, 0);
      idle(1);
      do_reset();
      @(negedge clk);
      chk("mid_valid", 32'(out_valid), 32'd0);
      chk("mid_count", 32'(count), 32'd0);
      chk("mid_err", 32'(err), 32'd0);
      @(posedge clk); #1;
      dq.delete();
      out_ready = 1'b1;
      send(ORD_SW, 1, 2, 0, 0, 8, 0);
      idle(2);
      chk("mid_n", 32'(dq.size()), 32'd1);
      if (dq.size() >= 1) chk("mid_addr", dq[0][31:0], 32'h3000);

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         reset     = ($urandom_range(0, 299) == 0);
         in_valid  = ($urandom_range(0, 2) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         in_order  = 7'($urandom_range(0, 63));
         in_rs = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
         in_shamt = 5'($urandom); in_imm = 16'($urandom); in_target = 26'($urandom);
         @(posedge clk); #1;
      end
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      idle(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Pipelined instruction encoder: accepts one decoded operation per handshake and emits the 32-bit MIPS machine word. Operations use the shared `order` codes from `CONST.v`, the same encoding the decode stage produces. Each emitted word is tagged with a sequential word address, so the encoder can stream programs into instruction memory or feed decode-stage self-checks. A one-entry registered output stage with full valid/ready backpressure sits between the producer and the memory writer.

## Interface
- BASE_ADDR, 32'h0000_3000, address tagged on the first word after reset
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  producer offers an operation
- in_ready  out  1  encoder accepts the offered operation this cycle
- in_order  in  7  `CONST.v` order code
- in_rs  in  5  rs field
- in_rt  in  5  rt field
- in_rd  in  5  rd field
- in_shamt  in  5  shift amount
- in_imm  in  16  immediate / branch offset
- in_target  in  26  jump target field
- out_valid  out  1  out_instr/out_addr hold a word
- out_ready  in  1  consumer takes the word
- out_instr  out  32  encoded machine word
- out_addr  out  32  word address of out_instr
- err  out  1  sticky: an illegal order was consumed
- count  out  16  words delivered (out handshakes), wraps

## Operation
- Input accept: in_valid && in_ready. Output delivery: out_valid && out_ready.
- in_ready = !out_valid || out_ready. It is combinational, with no path from in_valid.
- On a legal accept: out_instr <= encode(in_*), out_addr <= next_addr, next_addr <= next_addr + 4 (mod 2^32), out_valid <= 1.
- On an illegal accept (`none` or any unlisted code): the operation is consumed and dropped. err <= 1. next_addr is unchanged. out_valid <= 0 if the current word was delivered this cycle.
- Delivery with no accept: out_valid <= 0. With no delivery and no accept, all outputs hold.
- count increments on every delivery, 16'hFFFF -> 0.
- Encoding rule: every field not listed for an order is forced to zero, whatever its input value.
  - sll/srl/sra: op 0, rt, rd, shamt, funct 0/2/3.
  - sllv/srlv/srav: rs, rt, rd, funct 4/6/7.
  - jr: rs only, funct 8. jalr: rs, rd, funct 9.
  - mfhi/mflo: rd, funct 16/18. mthi/mtlo: rs, funct 17/19.
  - mult/multu/div/divu: rs, rt, funct 24–27.
  - add/addu/sub/subu/and/or/xor/nor/slt/sltu: rs, rt, rd, funct 32–39, 42, 43.
  - bltz/bgez: op 1, rs, rt field = 0/1, imm.
  - j/jal: op 2/3, target.
  - beq/bne: op 4/5, rs, rt, imm. blez/bgtz: op 6/7, rs, imm.
  - addi..xori: op 8–14, rs, rt, imm. lui: op 15, rt, imm.
  - mfc0/mtc0: op 16, rs field 0/4, rt, rd, low 11 bits 0.
  - eret: 32'h4200_0018 constant.
  - lb/lh/lw/lbu/lhu/sb/sh/sw: op 32/33/35/36/37/40/41/43, rs, rt, imm.

## Timing
- Latency: one cycle from accept to out_valid.
- Throughput: 1 word per cycle while out_ready stays high.
- Reset values: out_valid 0, out_instr 0, out_addr BASE_ADDR, next_addr BASE_ADDR, err 0, count 0. in_ready is therefore 1 during the cycle after reset.
- reset dominates all handshakes, including a mid-stream stall. A word pending when reset is asserted is discarded and not counted.
- While out_valid && !out_ready: out_instr, out_addr and out_valid are stable, and in_ready is 0.
- Delivery and accept in the same cycle: the new word replaces the old one with no bubble. count increments and out_addr advances by 4.
- err clears only on reset.

## Test plan
- Reset, then send addu rs=1 rt=2 rd=3, then ori rs=0 rt=1 imm=16'h1234, with out_ready held 1. Expect out_instr 32'h0022_1821 @ 32'h3000, then 32'h3401_1234 @ 32'h3004. count ends at 2.
- Field masking: send sll rt=1 rd=2 shamt=4 with in_rs=31 and in_imm=16'hFFFF. Expect 32'h0001_1100.
- Special encodings: eret -> 32'h4200_0018. jal target=26'h0000C03 -> 32'h0C00_0C03. bgez rs=5 imm=16'hFFFE -> 32'h04A1_FFFE. mtc0 rt=2 rd=12 -> 32'h4082_6000.
- Backpressure: stream 4 ops with out_ready low for 3 cycles after the first word. Expect out_instr and out_addr held, in_ready 0 during the stall, then back-to-back delivery at 32'h3000..32'h300C with no loss or duplication.
- Illegal: send `none`, then lw rs=29 rt=8 imm=4. Expect err=1, no word for `none`, and lw = 32'h8FA8_0004 at 32'h3000.
- Reset mid-stream: hold out_ready=0 with a word pending, then pulse reset. Next cycle expect out_valid 0, count 0, err 0, and the next word tagged 32'h3000.
